// File: rtl/wfsm_pkg.sv
// Shared definitions for the burst-master write FSM: state encoding and width defaults.
// Handshake pulses (FIFO pop, init_master_txn) are registered and exactly one cycle wide.
package wfsm_pkg;

    localparam int DATA_W_DEF  = 128;
    localparam int IDX_W_DEF   = 32;
    localparam int CNT_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 1024;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        FETCH       = 3'd1,
        LOAD        = 3'd2,
        LAUNCH      = 3'd3,
        WAIT_ACTIVE = 3'd4,
        WAIT_DONE   = 3'd5,
        DONE        = 3'd6
    } state_t;

    function automatic logic in_wait(state_t s);
        return (s == WAIT_ACTIVE) || (s == WAIT_DONE);
    endfunction

endpackage

// File: rtl/wfsm_if.sv
// Job control, output-FIFO and burst-master write signals of the write FSM.
interface wfsm_if
    import wfsm_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              start;
    logic [CNT_W-1:0]  number_blocks;
    logic              fifo_empty;
    logic              fifo_read_en;
    logic [DATA_W-1:0] fifo_read_data;
    logic [DATA_W-1:0] write_data;
    logic              init_master_txn;
    logic [IDX_W-1:0]  write_addr_index;
    logic              write_active;
    logic              write_done;
    logic              write_finished;
    logic              busy;
    logic [CNT_W-1:0]  blocks_written;
    logic              timeout_error;

    modport master (
        input  start, number_blocks, fifo_empty, fifo_read_data, write_active, write_done,
        output fifo_read_en, write_data, init_master_txn, write_addr_index,
               write_finished, busy, blocks_written, timeout_error
    );

    modport slave (
        output start, number_blocks, fifo_empty, fifo_read_data, write_active, write_done,
        input  fifo_read_en, write_data, init_master_txn, write_addr_index,
               write_finished, busy, blocks_written, timeout_error
    );
endinterface

// File: rtl/wfsm_watchdog.sv
// Per-transaction cycle counter; expired_o rises once TIMEOUT_CYCLES-1 enabled cycles elapse after load.
module wfsm_watchdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CW-1:0] cnt_q;

    assign expired_o = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end
endmodule

// File: rtl/wfsm.sv
// Write-side FSM: pops one result block per transaction from the output FIFO and
// sequences a single-beat write through the burst master's init/active/done handshake.
module wfsm
    import wfsm_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int IDX_W          = IDX_W_DEF,
    parameter int CNT_W          = CNT_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input logic    clk,
    input logic    reset,
    wfsm_if.master bus
);
    state_t            state_q;
    logic [CNT_W-1:0]  remaining_q;
    logic [CNT_W-1:0]  blocks_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ren_q;
    logic              init_q;
    logic              fin_q;
    logic              busy_q;
    logic              terr_q;

    logic wd_load;
    logic wd_en;
    logic wd_expired;
    logic txn_done;

    assign wd_load  = (state_q == LAUNCH);
    assign wd_en    = in_wait(state_q);
    // write_active and write_done together in WAIT_ACTIVE complete the block directly.
    assign txn_done = bus.write_done &&
                      ((state_q == WAIT_DONE) || (state_q == WAIT_ACTIVE && bus.write_active));

    wfsm_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .load_i   (wd_load),
        .en_i     (wd_en),
        .expired_o(wd_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            blocks_q    <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            ren_q       <= 1'b0;
            init_q      <= 1'b0;
            fin_q       <= 1'b0;
            busy_q      <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            ren_q  <= 1'b0;
            init_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        remaining_q <= bus.number_blocks;
                        blocks_q    <= '0;
                        idx_q       <= '0;
                        fin_q       <= 1'b0;
                        terr_q      <= 1'b0;
                        if (bus.number_blocks != '0) begin
                            state_q <= FETCH;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                        end
                    end else if (state_q == DONE) begin
                        // A zero-block job reaches DONE with the flag still clear; raise it here.
                        fin_q <= 1'b1;
                    end
                end
                FETCH: begin
                    if (!bus.fifo_empty) begin
                        ren_q   <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    state_q <= LAUNCH;
                end
                LAUNCH: begin
                    // The pop issued during LOAD presents its data in this cycle.
                    wdata_q <= bus.fifo_read_data;
                    init_q  <= 1'b1;
                    state_q <= WAIT_ACTIVE;
                end
                WAIT_ACTIVE, WAIT_DONE: begin
                    if (txn_done) begin
                        idx_q       <= idx_q + IDX_W'(1);
                        blocks_q    <= blocks_q + CNT_W'(1);
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q > CNT_W'(1)) begin
                            state_q <= FETCH;
                        end else begin
                            state_q <= DONE;
                            fin_q   <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else if (wd_expired) begin
                        terr_q  <= 1'b1;
                        fin_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end else if (state_q == WAIT_ACTIVE && bus.write_active) begin
                        state_q <= WAIT_DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fifo_read_en     = ren_q;
    assign bus.write_data       = wdata_q;
    assign bus.init_master_txn  = init_q;
    assign bus.write_addr_index = idx_q;
    assign bus.write_finished   = fin_q;
    assign bus.busy             = busy_q;
    assign bus.blocks_written   = blocks_q;
    assign bus.timeout_error    = terr_q;
endmodule

// File: tb/tb_wfsm.sv
// Directed bench for wfsm: FIFO model, latency-programmable master responder, hand-computed expectations.
module tb_wfsm;
    localparam logic [127:0] DA  = {4{32'hA0A0_0001}};
    localparam logic [127:0] DB  = {4{32'hB0B0_0002}};
    localparam logic [127:0] DC  = {4{32'hC0C0_0003}};
    localparam logic [127:0] D1  = {4{32'hD1D1_0004}};
    localparam logic [127:0] D2  = {4{32'hD2D2_0005}};
    localparam logic [127:0] DT  = {4{32'hEEEE_0006}};
    localparam logic [127:0] DR1 = {4{32'h1111_0007}};
    localparam logic [127:0] DR2 = {4{32'h2222_0008}};
    localparam logic [127:0] DS1 = {4{32'h3333_0009}};
    localparam logic [127:0] DS2 = {4{32'h4444_000A}};

    logic clk = 1'b0;
    logic reset;

    wfsm_if #(.DATA_W(128), .IDX_W(32), .CNT_W(16)) bus ();

    wfsm #(.DATA_W(128), .IDX_W(32), .CNT_W(16), .TIMEOUT_CYCLES(16)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int errs   = 0;
    int checks = 0;

    // FIFO model: entries pushed by the stimulus, popped on fifo_read_en, data one cycle later.
    logic [127:0] mem [0:63];
    int           wp = 0;
    int           rp = 0;
    logic [127:0] rd = '0;

    assign bus.fifo_empty     = (rp == wp);
    assign bus.fifo_read_data = rd;

    always @(posedge clk) begin
        if (bus.fifo_read_en && rp != wp) begin
            rd <= mem[rp % 64];
            rp <= rp + 1;
        end
    end

    // Master responder: write_active / write_done pulse act_lat / done_lat cycles after init (0 = never).
    int           act_lat = 2;
    int           done_lat = 5;
    int           age = 0;
    logic         outst = 1'b0;
    int           ninit = 0;
    int           wd_chg = 0;
    logic [127:0] cur_dat = '0;
    logic [127:0] log_dat [0:31];
    logic [31:0]  log_idx [0:31];

    initial begin
        bus.write_active = 1'b0;
        bus.write_done   = 1'b0;
    end

    always @(posedge clk) begin
        if (reset) begin
            outst            <= 1'b0;
            age              <= 0;
            bus.write_active <= 1'b0;
            bus.write_done   <= 1'b0;
        end else if (bus.init_master_txn) begin
            outst                <= 1'b1;
            age                  <= 1;
            bus.write_active     <= (act_lat == 1);
            bus.write_done       <= (done_lat == 1);
            cur_dat              <= bus.write_data;
            log_dat[ninit % 32]  <= bus.write_data;
            log_idx[ninit % 32]  <= bus.write_addr_index;
            ninit                <= ninit + 1;
        end else if (outst) begin
            if (bus.write_done) begin
                outst            <= 1'b0;
                bus.write_active <= 1'b0;
                bus.write_done   <= 1'b0;
            end else begin
                age              <= age + 1;
                bus.write_active <= (act_lat == age + 1);
                bus.write_done   <= (done_lat == age + 1);
                if (bus.write_data !== cur_dat) wd_chg <= wd_chg + 1;
            end
        end else begin
            bus.write_active <= 1'b0;
            bus.write_done   <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [127:0] d);
        mem[wp % 64] = d;
        wp++;
    endtask

    task automatic pulse_start(input logic [15:0] nb);
        bus.number_blocks = nb;
        bus.start         = 1'b1;
        @(negedge clk);
        bus.start         = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        int n = 0;
        while (bus.init_master_txn !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 128'(n < 200), 128'd1);
    endtask

    task automatic wait_fin(input string tag);
        int n = 0;
        while (bus.write_finished !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 128'(n < 400), 128'd1);
    endtask

    initial begin
        int n0;
        int p0;
        reset             = 1'b1;
        bus.start         = 1'b0;
        bus.number_blocks = '0;
        repeat (2) @(negedge clk);
        chk("rst_fin", bus.write_finished, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_idx", bus.write_addr_index, 0);
        chk("rst_wdata", bus.write_data, 0);
        chk("rst_blk", bus.blocks_written, 0);
        chk("rst_init", bus.init_master_txn, 0);
        reset = 1'b0;
        @(negedge clk);

        // Three preloaded blocks, master answers 2/5 cycles after init.
        push(DA); push(DB); push(DC);
        n0 = ninit; p0 = rp;
        pulse_start(3);
        chk("t1_busy", bus.busy, 1);
        wait_fin("t1_fin");
        chk("t1_ninit", ninit - n0, 3);
        chk("t1_idx0", log_idx[n0 % 32], 0);
        chk("t1_idx1", log_idx[(n0 + 1) % 32], 1);
        chk("t1_idx2", log_idx[(n0 + 2) % 32], 2);
        chk("t1_dat0", log_dat[n0 % 32], DA);
        chk("t1_dat1", log_dat[(n0 + 1) % 32], DB);
        chk("t1_dat2", log_dat[(n0 + 2) % 32], DC);
        chk("t1_blk", bus.blocks_written, 3);
        chk("t1_pops", rp - p0, 3);
        chk("t1_busy_end", bus.busy, 0);
        chk("t1_terr", bus.timeout_error, 0);

        // Zero-block job.
        n0 = ninit; p0 = rp;
        pulse_start(0);
        chk("t2_fin_s1", bus.write_finished, 0);
        chk("t2_busy", bus.busy, 0);
        @(negedge clk);
        chk("t2_fin_s2", bus.write_finished, 1);
        repeat (3) @(negedge clk);
        chk("t2_pops", rp - p0, 0);
        chk("t2_ninit", ninit - n0, 0);

        // Empty FIFO: FSM must wait in FETCH.
        n0 = ninit; p0 = rp;
        pulse_start(2);
        repeat (10) @(negedge clk);
        chk("t3_wait_busy", bus.busy, 1);
        chk("t3_wait_pops", rp - p0, 0);
        chk("t3_wait_init", ninit - n0, 0);
        push(D1);
        wait_init("t3_init");
        repeat (10) @(negedge clk);
        push(D2);
        wait_fin("t3_fin");
        chk("t3_ninit", ninit - n0, 2);
        chk("t3_dat0", log_dat[n0 % 32], D1);
        chk("t3_dat1", log_dat[(n0 + 1) % 32], D2);
        chk("t3_idx1", log_idx[(n0 + 1) % 32], 1);
        chk("t3_blk", bus.blocks_written, 2);
        chk("t3_pops", rp - p0, 2);

        // Watchdog: master never answers.
        act_lat = 0; done_lat = 0;
        push(DT);
        pulse_start(1);
        wait_init("t4_init");
        repeat (15) @(negedge clk);
        chk("t4_terr_early", bus.timeout_error, 0);
        @(negedge clk);
        chk("t4_terr", bus.timeout_error, 1);
        chk("t4_fin", bus.write_finished, 1);
        chk("t4_blk", bus.blocks_written, 0);
        chk("t4_busy", bus.busy, 0);
        pulse_start(0);
        chk("t4_terr_clr", bus.timeout_error, 0);
        chk("t4_fin_clr", bus.write_finished, 0);

        // Asynchronous reset while block 1 of 4 sits in WAIT_DONE.
        act_lat = 2; done_lat = 0;
        push(DR1); push(DR2);
        pulse_start(4);
        wait_init("t5_init");
        repeat (3) @(negedge clk);
        chk("t5_pre_wdata", bus.write_data, DR1);
        chk("t5_pre_busy", bus.busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("t5_wdata", bus.write_data, 0);
        chk("t5_busy", bus.busy, 0);
        chk("t5_init", bus.init_master_txn, 0);
        chk("t5_ren", bus.fifo_read_en, 0);
        chk("t5_fin", bus.write_finished, 0);
        @(negedge clk);
        reset = 1'b0;
        n0 = ninit; p0 = rp;
        repeat (5) @(negedge clk);
        chk("t5_no_init", ninit - n0, 0);
        chk("t5_no_pop", rp - p0, 0);
        act_lat = 2; done_lat = 5;
        pulse_start(1);
        wait_fin("t5_fin2");
        chk("t5_ninit2", ninit - n0, 1);
        chk("t5_idx2", log_idx[n0 % 32], 0);
        chk("t5_dat2", log_dat[n0 % 32], DR2);
        chk("t5_blk2", bus.blocks_written, 1);

        // Start while busy is ignored; active and done together finish the block in WAIT_ACTIVE.
        act_lat = 3; done_lat = 3;
        push(DS1); push(DS2);
        n0 = ninit; p0 = rp;
        pulse_start(2);
        wait_init("t6_init");
        bus.number_blocks = 16'd7;
        bus.start         = 1'b1;
        @(negedge clk);
        bus.start         = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_blk_w3", bus.blocks_written, 0);
        @(negedge clk);
        chk("t6_blk_w4", bus.blocks_written, 1);
        chk("t6_busy_w4", bus.busy, 1);
        wait_fin("t6_fin");
        chk("t6_blk", bus.blocks_written, 2);
        chk("t6_ninit", ninit - n0, 2);
        chk("t6_idx0", log_idx[n0 % 32], 0);
        chk("t6_idx1", log_idx[(n0 + 1) % 32], 1);
        chk("t6_dat1", log_dat[(n0 + 1) % 32], DS2);
        chk("t6_pops", rp - p0, 2);

        chk("wdata_stable", wd_chg, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
